fetch_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit lab processor. It sequences the program counter through LOAD_PC/INCR_PC and drives the memory handshake. It holds the instruction (IR) and operand (OPR) registers and issues the accumulator/ALU strobes. It sits between the program counter, the shared instruction/data memory and the accumulator datapath.

---
 rtl/fetch_ctrl_if.sv | 46 ++++
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bus bundle between fetch_ctrl and the PC / memory / accumulator datapath.
//
//   run        datapath -> ctrl   start request, sampled only in IDLE
//   mem_rdata  memory   -> ctrl   read data, valid while mem_ack=1
//   mem_ack    memory   -> ctrl   completion of the outstanding mem_rd/mem_wr
//   zero       datapath -> ctrl   accumulator-zero flag
//   LOAD_PC    ctrl -> PC         PC <= ADDR on the next edge
//   INCR_PC    ctrl -> PC         PC <= PC+1 on the next edge
//   ADDR       ctrl -> PC/memory  jump target / data address (always equals OPR)
//   ADDR_SEL   ctrl -> memory     address mux: 0 = PC, 1 = OPR
//   mem_rd     ctrl -> memory     read request (level, held through the ack cycle)
//   mem_wr     ctrl -> memory     write request, data is the accumulator
//   LOAD_ACC   ctrl -> datapath   ACC <= ALU result this edge
//   ALU_OP     ctrl -> datapath   00 pass, 01 add, 10 subtract
//   halted     ctrl -> outside    high in HALT
//   state      ctrl -> outside    encoded FSM state, for debug
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              run;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              zero;
  logic              LOAD_PC;
  logic              INCR_PC;
  logic [ADDR_W-1:0] ADDR;
  logic              ADDR_SEL;
  logic              mem_rd;
  logic              mem_wr;
  logic              LOAD_ACC;
  logic [1:0]        ALU_OP;
  logic              halted;
  logic [2:0]        state;

  // Controller side.
  modport master (
    input  run, mem_rdata, mem_ack, zero,
    output LOAD_PC, INCR_PC, ADDR, ADDR_SEL, mem_rd, mem_wr, LOAD_ACC, ALU_OP, halted, state
  );

  // Datapath / memory side.
  modport slave (
    output run, mem_rdata, mem_ack, zero,
    input  LOAD_PC, INCR_PC, ADDR, ADDR_SEL, mem_rd, mem_wr, LOAD_ACC, ALU_OP, halted, state
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch/decode/execute controller for the 8-bit lab processor.
// Sequences the external PC, runs the level memory handshake, holds IR and OPR and issues
// accumulator strobes.
//
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    if   fetch_ctrl_if.master (see interface file for the signal list)
module fetch_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetchOp  = 3'd1,
    StFetchArg = 3'd2,
    StExec     = 3'd3,
    StHalt     = 3'd4
  } state_e;

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpLda = 3'd1;
  localparam logic [2:0] OpSta = 3'd2;
  localparam logic [2:0] OpAdd = 3'd3;
  localparam logic [2:0] OpSub = 3'd4;
  localparam logic [2:0] OpJmp = 3'd5;
  localparam logic [2:0] OpJz  = 3'd6;
  localparam logic [2:0] OpHlt = 3'd7;

  state_e            state_q, state_d;
  // Only the opcode field of the instruction byte is ever decoded, so only it is stored.
  logic [2:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] opr_q, opr_d;

  logic       load_pc, incr_pc, addr_sel, mem_rd, mem_wr, load_acc;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      opr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
    load_pc  = 1'b0;
    incr_pc  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    load_acc = 1'b0;
    alu_op   = 2'b00;

    case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetchOp;
      end

      StFetchOp: begin
        mem_rd = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata[7:5];
          incr_pc = 1'b1;
          // Decode straight from the bus: IR is not yet loaded in this cycle.
          if (bus.mem_rdata[7:5] == OpNop || bus.mem_rdata[7:5] == OpHlt) begin
            state_d = StExec;
          end else begin
            state_d = StFetchArg;
          end
        end
      end

      StFetchArg: begin
        mem_rd = 1'b1;
        if (bus.mem_ack) begin
          opr_d   = ADDR_W'(bus.mem_rdata);
          incr_pc = 1'b1;
          state_d = StExec;
        end
      end

      StExec: begin
        unique case (ir_q)
          OpNop: state_d = StFetchOp;
          OpHlt: state_d = StHalt;
          OpJmp: begin
            load_pc = 1'b1;
            state_d = StFetchOp;
          end
          OpJz: begin
            load_pc = bus.zero;
            state_d = StFetchOp;
          end
          OpLda, OpAdd, OpSub: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            if (bus.mem_ack) begin
              load_acc = 1'b1;
              alu_op   = (ir_q == OpAdd) ? 2'b01 : (ir_q == OpSub) ? 2'b10 : 2'b00;
              state_d  = StFetchOp;
            end
          end
          OpSta: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
            if (bus.mem_ack) state_d = StFetchOp;
          end
        endcase
      end

      StHalt: begin
        state_d = StHalt;
      end

      // Codes 5-7 are unreachable in normal operation; recover to IDLE.
      default: state_d = StIdle;
    endcase
  end

  assign bus.LOAD_PC  = load_pc;
  assign bus.INCR_PC  = incr_pc;
  assign bus.ADDR     = opr_q;
  assign bus.ADDR_SEL = addr_sel;
  assign bus.mem_rd   = mem_rd;
  assign bus.mem_wr   = mem_wr;
  assign bus.LOAD_ACC = load_acc;
  assign bus.ALU_OP   = alu_op;
  assign bus.halted   = (state_q == StHalt);
  assign bus.state    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a small PC / memory / accumulator model.
module tb_fetch_ctrl;
  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Stimulus controls.
  logic       run_r = 1'b0;
  logic       zero_r = 1'b0;
  logic       force_ack = 1'b0;
  int         ws = 0;
  logic [7:0] rom [256];

  // Environment model state.
  logic [7:0] pc;
  int         wcnt;
  logic [7:0] acc;
  int         incr_cnt;
  int         loadpc_cnt;
  int         wr_cnt;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  wire       req      = bus.mem_rd | bus.mem_wr;
  wire       auto_ack = req && (wcnt == ws);
  wire [7:0] maddr    = bus.ADDR_SEL ? bus.ADDR : pc;

  assign bus.run       = run_r;
  assign bus.zero      = zero_r;
  assign bus.mem_ack   = force_ack | auto_ack;
  assign bus.mem_rdata = rom[maddr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= '0;
      wcnt <= 0;
      acc  <= '0;
    end else begin
      if (bus.LOAD_PC) pc <= bus.ADDR;
      else if (bus.INCR_PC) pc <= pc + 8'd1;
      if (req && !auto_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (bus.LOAD_ACC) begin
        case (bus.ALU_OP)
          2'b00:   acc <= bus.mem_rdata;
          2'b01:   acc <= acc + bus.mem_rdata;
          2'b10:   acc <= acc - bus.mem_rdata;
          default: acc <= acc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.INCR_PC) incr_cnt <= incr_cnt + 1;
    if (bus.LOAD_PC) loadpc_cnt <= loadpc_cnt + 1;
    if (bus.mem_wr && bus.mem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= maddr;
      wr_data <= acc;
    end
  end

  // Per-cycle invariant checks.
  always @(negedge clk) begin
    if (reset) begin
      compared++;
      if ((bus.INCR_PC & bus.LOAD_PC) !== 1'b0) begin
        mismatched++;
        $display("FAIL inv_pc_strobes: INCR_PC=%b LOAD_PC=%b, required not both", bus.INCR_PC,
                 bus.LOAD_PC);
      end
      compared++;
      if ((bus.mem_rd & bus.mem_wr) !== 1'b0) begin
        mismatched++;
        $display("FAIL inv_rd_wr: mem_rd=%b mem_wr=%b, required not both", bus.mem_rd,
                 bus.mem_wr);
      end
      compared++;
      if (bus.LOAD_ACC && !(bus.state == 3'd3 && bus.mem_ack)) begin
        mismatched++;
        $display("FAIL inv_load_acc: LOAD_ACC=1 state=%0d mem_ack=%b, required EXEC ack cycle",
                 bus.state, bus.mem_ack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    run_r     = 1'b0;
    zero_r    = 1'b0;
    force_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'hE0;
    ws = 0;
    reset = 1'b0;
    run_r = 1'b1;
    force_ack = 1'b1;
    repeat (3) tick();
    compared++;
    if ({bus.LOAD_PC, bus.INCR_PC, bus.ADDR_SEL, bus.mem_rd, bus.mem_wr, bus.LOAD_ACC,
         bus.halted} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got LP=%b IP=%b AS=%b RD=%b WR=%b LA=%b H=%b, required 0",
               bus.LOAD_PC, bus.INCR_PC, bus.ADDR_SEL, bus.mem_rd, bus.mem_wr, bus.LOAD_ACC,
               bus.halted);
    end
    compared++;
    if (bus.ADDR !== 8'h00 || bus.ALU_OP !== 2'b00 || bus.state !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_values: ADDR=%h ALU_OP=%b state=%0d, required 00/00/0", bus.ADDR,
               bus.ALU_OP, bus.state);
    end
    force_ack = 1'b0;
    run_r = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++;
      if (bus.state !== 3'd0 || bus.mem_rd !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_hold: cycle %0d state=%0d mem_rd=%b, required 0/0", k, bus.state,
                 bus.mem_rd);
      end
    end
    run_r = 1'b1;
    tick();
    run_r = 1'b0;
    compared++;
    if (bus.mem_rd !== 1'b1 || bus.ADDR_SEL !== 1'b0 || bus.state !== 3'd1) begin
      mismatched++;
      $display("FAIL start_fetch: mem_rd=%b ADDR_SEL=%b state=%0d, required 1/0/1", bus.mem_rd,
               bus.ADDR_SEL, bus.state);
    end
  endtask

  task automatic test_nop_hlt();
    int i0, l0;
    clear_rom();
    rom[0] = 8'h00;
    rom[1] = 8'hE0;
    ws = 0;
    do_reset();
    i0 = incr_cnt;
    l0 = loadpc_cnt;
    run_r = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      run_r = 1'b0;
      if (k == 4) begin
        compared++;
        if (bus.halted !== 1'b0) begin
          mismatched++;
          $display("FAIL nop_hlt_early: halted=%b at cycle 4, required 0", bus.halted);
        end
      end
      if (k == 5) begin
        compared++;
        if (bus.halted !== 1'b1) begin
          mismatched++;
          $display("FAIL nop_hlt_halt: halted=%b at cycle 5, required 1", bus.halted);
        end
      end
    end
    compared++;
    if (incr_cnt - i0 != 2 || loadpc_cnt - l0 != 0) begin
      mismatched++;
      $display("FAIL nop_hlt_pc: INCR_PC pulses=%0d LOAD_PC pulses=%0d, required 2/0",
               incr_cnt - i0, loadpc_cnt - l0);
    end
    run_r = 1'b1;
    repeat (3) tick();
    run_r = 1'b0;
    compared++;
    if (bus.state !== 3'd4 || bus.halted !== 1'b1 || bus.mem_rd !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_sticky: state=%0d halted=%b mem_rd=%b, required 4/1/0", bus.state,
               bus.halted, bus.mem_rd);
    end
  endtask

  task automatic test_lda_add_sta();
    int i0, w0, nacc, wrcyc, n;
    logic [1:0] ops [2];
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h20;  // LDA 0x20
    rom[2] = 8'h60; rom[3] = 8'h21;  // ADD 0x21
    rom[4] = 8'h40; rom[5] = 8'h22;  // STA 0x22
    rom[6] = 8'hE0;                  // HLT
    rom[8'h20] = 8'd5;
    rom[8'h21] = 8'd7;
    ws = 2;
    do_reset();
    i0 = incr_cnt;
    w0 = wr_cnt;
    nacc = 0;
    wrcyc = 0;
    n = 0;
    ops[0] = 2'b11;
    ops[1] = 2'b11;
    run_r = 1'b1;
    tick();
    run_r = 1'b0;
    while (!bus.halted && n < 200) begin
      if (bus.LOAD_ACC) begin
        if (nacc < 2) ops[nacc] = bus.ALU_OP;
        nacc++;
      end
      if (bus.mem_wr) begin
        wrcyc++;
        compared++;
        if (bus.ADDR !== 8'h22 || bus.ADDR_SEL !== 1'b1) begin
          mismatched++;
          $display("FAIL sta_addr: ADDR=%h ADDR_SEL=%b, required 22/1", bus.ADDR, bus.ADDR_SEL);
        end
      end
      tick();
      n++;
    end
    compared++;
    if (n >= 200) begin
      mismatched++;
      $display("FAIL lda_timeout: halted=%b after %0d cycles, required 1", bus.halted, n);
    end
    compared++;
    if (nacc != 2 || ops[0] !== 2'b00 || ops[1] !== 2'b01) begin
      mismatched++;
      $display("FAIL acc_ops: count=%0d ops=%b,%b, required 2 with 00,01", nacc, ops[0], ops[1]);
    end
    compared++;
    if (wrcyc != 3) begin
      mismatched++;
      $display("FAIL sta_hold: mem_wr cycles=%0d, required 3", wrcyc);
    end
    compared++;
    if (wr_cnt - w0 != 1 || wr_addr !== 8'h22 || wr_data !== 8'd12) begin
      mismatched++;
      $display("FAIL sta_data: writes=%0d addr=%h data=%0d, required 1/22/12", wr_cnt - w0,
               wr_addr, wr_data);
    end
    compared++;
    if (incr_cnt - i0 != 7) begin
      mismatched++;
      $display("FAIL lda_incr: INCR_PC pulses=%0d, required 7", incr_cnt - i0);
    end
  endtask

  task automatic test_jumps();
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h40;        // JZ 0x40 (zero=0)
    rom[2] = 8'hC0; rom[3] = 8'h40;        // JZ 0x40 (zero=1)
    rom[8'h40] = 8'hA0; rom[8'h41] = 8'h10; // JMP 0x10
    rom[8'h10] = 8'hE0;                    // HLT
    ws = 0;
    do_reset();
    run_r = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      run_r = 1'b0;
      case (k)
        3: begin
          compared++;
          if (bus.state !== 3'd3 || bus.LOAD_PC !== 1'b0) begin
            mismatched++;
            $display("FAIL jz_not_taken: state=%0d LOAD_PC=%b, required 3/0", bus.state,
                     bus.LOAD_PC);
          end
        end
        4: begin
          compared++;
          if (pc !== 8'h02 || bus.ADDR_SEL !== 1'b0 || bus.mem_rd !== 1'b1) begin
            mismatched++;
            $display("FAIL jz_fallthrough: pc=%h ADDR_SEL=%b mem_rd=%b, required 02/0/1", pc,
                     bus.ADDR_SEL, bus.mem_rd);
          end
          zero_r = 1'b1;
        end
        6: begin
          compared++;
          if (bus.LOAD_PC !== 1'b1 || bus.ADDR !== 8'h40) begin
            mismatched++;
            $display("FAIL jz_taken: LOAD_PC=%b ADDR=%h, required 1/40", bus.LOAD_PC, bus.ADDR);
          end
        end
        7: begin
          compared++;
          if (bus.LOAD_PC !== 1'b0 || pc !== 8'h40) begin
            mismatched++;
            $display("FAIL jz_target: LOAD_PC=%b pc=%h, required 0/40", bus.LOAD_PC, pc);
          end
        end
        9: begin
          compared++;
          if (bus.LOAD_PC !== 1'b1 || bus.ADDR !== 8'h10) begin
            mismatched++;
            $display("FAIL jmp_load: LOAD_PC=%b ADDR=%h, required 1/10", bus.LOAD_PC, bus.ADDR);
          end
        end
        10: begin
          compared++;
          if (pc !== 8'h10 || bus.ADDR_SEL !== 1'b0 || bus.mem_rd !== 1'b1 ||
              bus.LOAD_PC !== 1'b0) begin
            mismatched++;
            $display("FAIL jmp_fetch: pc=%h ADDR_SEL=%b mem_rd=%b LOAD_PC=%b, required 10/0/1/0",
                     pc, bus.ADDR_SEL, bus.mem_rd, bus.LOAD_PC);
          end
        end
        12: begin
          compared++;
          if (bus.halted !== 1'b1) begin
            mismatched++;
            $display("FAIL jmp_halt: halted=%b, required 1", bus.halted);
          end
        end
        default: ;
      endcase
    end
    zero_r = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'h04;  // JMP 0x04
    rom[4] = 8'h20; rom[5] = 8'h20;  // LDA 0x20
    ws = 3;
    do_reset();
    run_r = 1'b1;
    n = 0;
    tick();
    run_r = 1'b0;
    while (!(bus.state == 3'd2 && pc == 8'h05) && n < 60) begin
      tick();
      n++;
    end
    compared++;
    if (n >= 60) begin
      mismatched++;
      $display("FAIL mid_reach: state=%0d pc=%h, required FETCH_ARG at pc 05", bus.state, pc);
    end
    force_ack = 1'b1;
    #2;
    compared++;
    if (bus.INCR_PC !== 1'b1 || bus.mem_rd !== 1'b1 || bus.ADDR !== 8'h04) begin
      mismatched++;
      $display("FAIL mid_before: INCR_PC=%b mem_rd=%b ADDR=%h, required 1/1/04", bus.INCR_PC,
               bus.mem_rd, bus.ADDR);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (bus.INCR_PC !== 1'b0 || bus.mem_rd !== 1'b0 || bus.ADDR !== 8'h00 ||
        bus.state !== 3'd0) begin
      mismatched++;
      $display("FAIL mid_async: INCR_PC=%b mem_rd=%b ADDR=%h state=%0d, required 0/0/00/0",
               bus.INCR_PC, bus.mem_rd, bus.ADDR, bus.state);
    end
    force_ack = 1'b0;
    tick();
    reset = 1'b1;
    ws = 0;
    run_r = 1'b1;
    tick();
    run_r = 1'b0;
    compared++;
    if (bus.state !== 3'd1 || bus.mem_rd !== 1'b1 || bus.ADDR_SEL !== 1'b0 || pc !== 8'h00) begin
      mismatched++;
      $display("FAIL mid_restart: state=%0d mem_rd=%b ADDR_SEL=%b pc=%h, required 1/1/0/00",
               bus.state, bus.mem_rd, bus.ADDR_SEL, pc);
    end
  endtask

  task automatic test_stray_ack();
    int i0;
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'h02;  // JMP 0x02
    rom[2] = 8'h00;                  // NOP
    rom[3] = 8'hE0;                  // HLT
    ws = 0;
    do_reset();
    i0 = incr_cnt;
    force_ack = 1'b1;
    #1;
    compared++;
    if (bus.INCR_PC !== 1'b0 || bus.LOAD_ACC !== 1'b0 || bus.mem_rd !== 1'b0) begin
      mismatched++;
      $display("FAIL stray_idle_comb: INCR_PC=%b LOAD_ACC=%b mem_rd=%b, required 0/0/0",
               bus.INCR_PC, bus.LOAD_ACC, bus.mem_rd);
    end
    tick();
    force_ack = 1'b0;
    compared++;
    if (bus.state !== 3'd0 || bus.ADDR !== 8'h00) begin
      mismatched++;
      $display("FAIL stray_idle: state=%0d ADDR=%h, required 0/00", bus.state, bus.ADDR);
    end
    run_r = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      run_r = 1'b0;
      if (k == 5) begin
        force_ack = 1'b1;
        #1;
        compared++;
        if (bus.state !== 3'd3 || bus.INCR_PC !== 1'b0 || bus.LOAD_ACC !== 1'b0 ||
            bus.mem_rd !== 1'b0) begin
          mismatched++;
          $display("FAIL stray_exec: state=%0d INCR_PC=%b LOAD_ACC=%b mem_rd=%b, required 3/0/0/0",
                   bus.state, bus.INCR_PC, bus.LOAD_ACC, bus.mem_rd);
        end
      end
      if (k == 6) begin
        force_ack = 1'b0;
        compared++;
        if (bus.state !== 3'd1 || bus.ADDR !== 8'h02 || pc !== 8'h03) begin
          mismatched++;
          $display("FAIL stray_after: state=%0d ADDR=%h pc=%h, required 1/02/03", bus.state,
                   bus.ADDR, pc);
        end
      end
    end
    compared++;
    if (bus.halted !== 1'b1 || incr_cnt - i0 != 4) begin
      mismatched++;
      $display("FAIL stray_end: halted=%b INCR_PC pulses=%0d, required 1/4", bus.halted,
               incr_cnt - i0);
    end
  endtask

  initial begin
    test_reset();
    test_nop_hlt();
    test_lda_add_sta();
    test_jumps();
    test_reset_mid();
    test_stray_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
